// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 calculator keypad scanner.
//   - scan_state_e : scanner FSM encoding
//   - N_ROWS/N_COLS: matrix geometry
//   - col_onehot   : column index -> one-hot column drive
//   - low_row      : lowest active row index (R1 has priority)
//   - key_sym      : key index (row*4+col) -> ASCII symbol for the calculator
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } scan_state_e;

    function automatic logic [N_COLS-1:0] col_onehot(input logic [1:0] col);
        logic [N_COLS-1:0] oh;
        oh = '0;
        oh[col] = 1'b1;
        return oh;
    endfunction

    // Lowest set bit wins, so R1 beats R2 beats R3 beats R4.
    function automatic logic [1:0] low_row(input logic [N_ROWS-1:0] rows);
        logic [1:0] r;
        r = 2'd0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Keypad legend, row-major:
    //   1 2 3 +
    //   4 5 6 -
    //   7 8 9 *
    //   C 0 = /
    function automatic logic [7:0] key_sym(input logic [3:0] idx);
        logic [7:0] s;
        case (idx)
            4'd0:  s = "1";
            4'd1:  s = "2";
            4'd2:  s = "3";
            4'd3:  s = "+";
            4'd4:  s = "4";
            4'd5:  s = "5";
            4'd6:  s = "6";
            4'd7:  s = "-";
            4'd8:  s = "7";
            4'd9:  s = "8";
            4'd10: s = "9";
            4'd11: s = "*";
            4'd12: s = "C";
            4'd13: s = "0";
            4'd14: s = "=";
            default: s = "/";
        endcase
        return s;
    endfunction

endpackage

// File: rtl/row_sync.sv
// row_sync: W-bit two-flop synchroniser for the asynchronous keypad rows.
//   Clk     : system clock
//   Reset_n : async active-low clear of both flop stages
//   d       : raw asynchronous rows
//   q       : synchronised rows (two clocks of latency)
module row_sync #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-drive scanner, debouncer and encoder for the 4x4
// calculator keypad.
//   Clk, Reset_n   : clock, async active-low reset
//   enable         : scanning allowed; low parks the scanner with columns off
//   R1..R4         : row returns (active-high, asynchronous)
//   C[3:0]         : one-hot column drive (registered)
//   keyCode[3:0]   : row*4+col of the last accepted key
//   keyValid       : one-cycle strobe when keyCode updates
//   keyHeld        : accepted key not yet released (release debounced)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8,
    parameter int CNT_W        = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       enable,
    input  logic       R1,
    input  logic       R2,
    input  logic       R3,
    input  logic       R4,
    output logic [3:0] C,
    output logic [3:0] keyCode,
    output logic       keyValid,
    output logic       keyHeld
);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    // The sample that triggers the transition is itself one of the
    // DEBOUNCE_CNT, so the decision is taken when count == DEBOUNCE_CNT-1.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);

    logic [N_ROWS-1:0] rs;

    row_sync #(.W(N_ROWS)) u_row_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d       ({R4, R3, R2, R1}),
        .q       (rs)
    );

    scan_state_e      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_d;
    logic             accept;
    logic             en_q;
    logic [3:0]       c_q;
    logic [3:0]       code_q;
    logic             valid_q;
    logic             held_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        accept  = 1'b0;
        if (!enable) begin
            state_d = SCAN;
            col_d   = 2'd0;
            cnt_d   = '0;
            held_d  = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    // en_q low means columns were off last cycle; the slot
                    // timer starts only once column 0 is actually driven.
                    if (en_q) begin
                        if (cnt_q >= SLOT_LAST) begin
                            if (rs == '0) begin
                                col_d = col_q + 2'd1;
                                cnt_d = '0;
                            end else begin
                                row_d   = low_row(rs);
                                state_d = DEBOUNCE;
                                cnt_d   = CNT_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (rs[row_q]) begin
                        if (cnt_q >= DB_LAST) begin
                            accept  = 1'b1;
                            state_d = HOLD;
                            cnt_d   = '0;
                            held_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    // Any row activity (this key or another) restarts the
                    // release count, so bounces cannot re-trigger.
                    if (rs != '0) begin
                        cnt_d = '0;
                    end else if (cnt_q >= DB_LAST) begin
                        state_d = SCAN;
                        col_d   = 2'd0;
                        cnt_d   = '0;
                        held_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = SCAN;
                    col_d   = 2'd0;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            c_q     <= 4'b0001;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            en_q    <= enable;
            // Column drive is registered from the next column so it changes
            // in the same cycle as the FSM and stays glitch-free.
            c_q     <= enable ? col_onehot(col_d) : 4'b0000;
            valid_q <= accept;
            held_q  <= held_d;
            if (accept) code_q <= {row_q, col_q};
        end
    end

    assign C        = c_q;
    assign keyCode  = code_q;
    assign keyValid = valid_q;
    assign keyHeld  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_CNT=8. A key matrix model turns pressed keys plus the column
// drive back into row lines, as the real keypad would.
module tb_keypad_scanner;

    logic       Clk;
    logic       Reset_n;
    logic       enable;
    logic       R1, R2, R3, R4;
    logic [3:0] C;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyHeld;

    // pk[row][col] = 1 while that key is physically pressed
    logic [3:0][3:0] pk;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int vcnt   = 0;
    int v0;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8),
        .CNT_W        (8)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .enable   (enable),
        .R1       (R1),
        .R2       (R2),
        .R3       (R3),
        .R4       (R4),
        .C        (C),
        .keyCode  (keyCode),
        .keyValid (keyValid),
        .keyHeld  (keyHeld)
    );

    assign R1 = |(pk[0] & C);
    assign R2 = |(pk[1] & C);
    assign R3 = |(pk[2] & C);
    assign R4 = |(pk[3] & C);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Count keyValid pulses (sampled pre-edge, so each pulse counts once).
    always @(posedge Clk) begin
        if (keyValid === 1'b1) vcnt <= vcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        pk      = '0;
        enable  = 1'b1;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_C", 32'(C), 32'h1);
        chk("rst_code", 32'(keyCode), 32'h0);
        chk("rst_valid", 32'(keyValid), 32'h0);
        chk("rst_held", 32'(keyHeld), 32'h0);

        // Idle scan: each column held for 4 clocks, wrapping 3 -> 0.
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] e;
            @(negedge Clk);
            e = 4'b0001 << (((k + 1) / 4) % 4);
            chk($sformatf("idle_C_%0d", k), 32'(C), 32'(e));
        end
        chk("idle_novalid", 32'(vcnt), 32'd0);

        // Single press of key 9 (row 2, col 1).
        v0 = vcnt;
        pk[2][1] = 1'b1;
        repeat (40) @(negedge Clk);
        chk("k9_pulses", 32'(vcnt), 32'(v0 + 1));
        chk("k9_code", 32'(keyCode), 32'd9);
        chk("k9_held", 32'(keyHeld), 32'd1);
        chk("k9_C", 32'(C), 32'b0010);
        pk = '0;
        // 2 sync clocks + 8 clean samples: held through 9 edges, low at 10th.
        repeat (9) @(negedge Clk);
        chk("k9_held_late", 32'(keyHeld), 32'd1);
        @(negedge Clk);
        chk("k9_released", 32'(keyHeld), 32'd0);
        chk("k9_C_restart", 32'(C), 32'b0001);

        // Release bounce on key 9: no second event.
        v0 = vcnt;
        pk[2][1] = 1'b1;
        repeat (40) @(negedge Clk);
        chk("rb_pulse", 32'(vcnt), 32'(v0 + 1));
        for (int i = 0; i < 3; i++) begin
            pk = '0;
            repeat (5) @(negedge Clk);
            pk[2][1] = 1'b1;
            repeat (2) @(negedge Clk);
        end
        chk("rb_held_bounce", 32'(keyHeld), 32'd1);
        pk = '0;
        repeat (9) @(negedge Clk);
        chk("rb_held_late", 32'(keyHeld), 32'd1);
        @(negedge Clk);
        chk("rb_released", 32'(keyHeld), 32'd0);
        chk("rb_single", 32'(vcnt), 32'(v0 + 1));

        // Bounce rejection: key (1,3) toggled every 3 cycles.
        v0 = vcnt;
        for (int i = 0; i < 10; i++) begin
            pk[1][3] = (i % 2 == 0);
            repeat (3) @(negedge Clk);
        end
        pk = '0;
        repeat (4) @(negedge Clk);
        chk("bnc_novalid", 32'(vcnt), 32'(v0));
        chk("bnc_noheld", 32'(keyHeld), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge Clk);
                if (C === 4'b0001) seen = 1'b1;
            end
            chk("bnc_col0_resume", 32'(seen), 32'd1);
        end

        // Priority: R1 and R4 both on column 2 -> key 2.
        v0 = vcnt;
        pk[0][2] = 1'b1;
        pk[3][2] = 1'b1;
        repeat (40) @(negedge Clk);
        chk("pri_pulse", 32'(vcnt), 32'(v0 + 1));
        chk("pri_code", 32'(keyCode), 32'd2);
        pk = '0;
        for (int i = 0; i < 30 && keyHeld; i++) @(negedge Clk);
        chk("pri_released", 32'(keyHeld), 32'd0);

        // This negedge directly follows the release edge: SCAN, col 0, count 0.
        // Key (1,2) enters DEBOUNCE after 12 edges and reaches count 5 at 16.
        pk[1][2] = 1'b1;
        repeat (16) @(negedge Clk);
        chk("en_C_before", 32'(C), 32'b0100);
        chk("en_held_before", 32'(keyHeld), 32'd0);
        v0 = vcnt;
        enable = 1'b0;
        @(negedge Clk);
        chk("en_C_off", 32'(C), 32'b0000);
        repeat (10) @(negedge Clk);
        chk("en_novalid", 32'(vcnt), 32'(v0));
        chk("en_code_kept", 32'(keyCode), 32'd2);
        chk("en_noheld", 32'(keyHeld), 32'd0);
        pk = '0;
        enable = 1'b1;
        @(negedge Clk);
        chk("en_C_back", 32'(C), 32'b0001);

        // Reset while holding key 0.
        v0 = vcnt;
        pk[0][0] = 1'b1;
        repeat (40) @(negedge Clk);
        chk("rh_pulse", 32'(vcnt), 32'(v0 + 1));
        chk("rh_code", 32'(keyCode), 32'd0);
        chk("rh_held", 32'(keyHeld), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("rh_held_rst", 32'(keyHeld), 32'd0);
        chk("rh_C_rst", 32'(C), 32'b0001);
        chk("rh_valid_rst", 32'(keyValid), 32'd0);
        pk = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        chk("rh_after", 32'(vcnt), 32'(v0 + 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the column lines of the calculator's 4x4 matrix keypad and reads back the row lines.
- Debounces and encodes one keypress into a 4-bit key index with a single-cycle valid strobe.
- The existing row-side press detector only reports "some row active". This block is the column-drive side: it scans, resolves which key was pressed, and hands a clean event to the calculator control FSM.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven during scanning (min 3, to cover the 2-flop row synchroniser).
- DEBOUNCE_CNT, 8: consecutive stable samples required to accept a press or a release (min 1).
- CNT_W, 8: width of the shared slot/debounce counter; must hold max(SCAN_DIV, DEBOUNCE_CNT).

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: scanning allowed.
- R1, input, 1: row 0, active-high, asynchronous to Clk.
- R2, input, 1: row 1, active-high, asynchronous to Clk.
- R3, input, 1: row 2, active-high, asynchronous to Clk.
- R4, input, 1: row 3, active-high, asynchronous to Clk.
- C, output, 4: column drive, one-hot active-high; bit i drives column i.
- keyCode, output, 4: row*4 + col of the last accepted key.
- keyValid, output, 1: one-cycle pulse when keyCode is updated.
- keyHeld, output, 1: high from acceptance until the release is debounced.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - State SCAN, column 0, counters 0.
  - C=4'b0001, keyCode=0, keyValid=0, keyHeld=0.
  - Synchroniser flops cleared.
- Rows pass through a 2-flop synchroniser; every decision below uses synchronised rows (rs[3:0]).
- enable=0 (any state):
  - Next cycle C=4'b0000, state forced to SCAN, column 0, counters 0, keyHeld=0.
  - keyValid never asserts; keyCode is held.
  - When enable returns to 1, C=4'b0001 the next cycle.
- SCAN:
  - C is one-hot on the current column, held for SCAN_DIV cycles.
  - On the last cycle of the slot, sample rs.
  - rs==0: advance to the next column, wrapping col 3 -> col 0.
  - rs!=0: latch col and the lowest set row index (priority R1 > R2 > R3 > R4); go to DEBOUNCE with the count set to 1; C stays on the latched column.
- DEBOUNCE:
  - Each cycle, check the latched row bit of rs.
  - Bit high: count++.
  - Bit low: return to SCAN at the next column (wrap), no event.
  - When count reaches DEBOUNCE_CNT: next cycle keyValid=1 for exactly one cycle, keyCode=row*4+col, keyHeld=1; go to HOLD with the count cleared.
- HOLD:
  - C stays on the latched column; other keys are ignored.
  - Each cycle with rs==0, count++; any rs!=0 clears the count.
  - When count reaches DEBOUNCE_CNT: keyHeld=0, go to SCAN at column 0.
- Guarantees:
  - Exactly one keyValid per debounced press, regardless of hold duration.
  - Bounces during HOLD never produce a second event.
  - A press shorter than DEBOUNCE_CNT samples produces no event.
- Multiple keys in the same column: the lowest row wins. Keys in other columns are not seen until release.
- Counters saturate and never wrap. The column index wraps modulo 4.
- Reset mid-operation: immediate return to reset values and no keyValid, even if a debounce was about to complete.

Decomposition:
- Shared package keypad_pkg holds:
  - The state encoding (SCAN=2'd0, DEBOUNCE=2'd1, HOLD=2'd2).
  - N_ROWS=4 and N_COLS=4.
  - A key-to-symbol map constant (index -> calculator digit/operator) for downstream use.
- One natural sub-module, row_sync: a 4-bit 2-flop synchroniser with async active-low clear on Reset_n.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=8.
- Reset / idle: Reset_n=0 then 1, rows 0 -> C=0001, 0010, 0100, 1000, 0001 cycling every 4 clocks; keyValid never asserts.
- Single press: hold R3 high only while C[1] is driven, for 40 cycles -> exactly one keyValid pulse with keyCode=9 (row 2, col 1); keyHeld=1 until 8 cycles of rs==0 after release; then C restarts at 0001.
- Bounce rejection: R2 high only while C[3] is driven, toggled every 3 cycles for 30 cycles and then released -> no keyValid; scan resumes at column 0 after wrap.
- Release bounce: after the key-9 press is accepted, make the rows bounce low/high for 5-cycle gaps, then release cleanly -> no second keyValid; keyHeld drops only after 8 clean cycles.
- Priority: R1 and R4 both high on column 2 -> keyCode=2, single pulse.
- Enable / reset mid-operation:
  - enable=0 during DEBOUNCE at count 5 -> C=0000 next cycle, no keyValid.
  - Separately, Reset_n pulsed low in HOLD -> keyHeld=0, C=0001 immediately.
